// File: rtl/instr_prefetch_pkg.sv
// instr_prefetch_pkg: shared constants and memory-side FSM encoding for the instruction prefetcher
package instr_prefetch_pkg;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam logic [31:0] PF_RESET_PC = 32'h0000_0000;
   typedef enum logic [1:0] {IDLE, REQ, GAP} pf_state_e;
endpackage

// File: rtl/instr_prefetch_if.sv
// instr_prefetch_if: enable/valid instruction handshake, used on both the CPU and the memory side
interface instr_prefetch_if;
   logic [31:0] addr;
   logic [31:0] result;
   logic        enable;
   logic        valid;
   modport master (output addr, enable, input result, valid);
   modport slave  (input addr, enable, output result, valid);
endinterface

// File: rtl/instr_pf_fifo.sv
// instr_pf_fifo: DEPTH x 32 circular instruction buffer with push/pop/clear
module instr_pf_fifo
   import instr_prefetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   clear,
   input  logic [31:0]            din,
   output logic [31:0]            dout,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [31:0]   buffer [DEPTH];
   logic [AW-1:0] rd, wr;
   assign dout = buffer[rd];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else if (clear) begin
         rd    <= wr;
         count <= '0;
      end else begin
         if (push) wr <= wr + AW'(1);
         if (pop) rd <= rd + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   always_ff @(posedge clk)
      if (push && !clear) buffer[wr] <= din;
endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: streams sequential words ahead of the PC, serves head hits in one cycle.
// Hit/redirect counters are built only when PREFETCH_STATS_EN is defined.
module instr_prefetch
   import instr_prefetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = PF_RESET_PC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   instr_prefetch_if.slave   cpu,
   instr_prefetch_if.master  mem,
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_redirects
);
   localparam int CW = $clog2(DEPTH) + 1;
   pf_state_e     state, state_nx;
   logic [CW-1:0] count, count_nx;
   logic [31:0]   head_addr, head_nx, fifo_out;
   logic          drop, redirect, hit, clear, done, push, issue;
   instr_pf_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(hit), .clear(clear),
      .din(mem.result), .dout(fifo_out), .count(count)
   );
   assign mem.enable = state == REQ;
   // issue decisions use post-edge head/count, so a redirect or pop re-aims the very next request
   always_comb begin
      redirect = !flush && cpu.enable && !cpu.valid && cpu.addr != head_addr;
      hit      = !flush && cpu.enable && !cpu.valid && cpu.addr == head_addr && count != '0;
      clear    = flush || redirect;
      done     = state == REQ && mem.valid;
      push     = done && !drop && !clear;
      head_nx  = redirect ? cpu.addr : hit ? head_addr + 32'd4 : head_addr;
      count_nx = clear ? '0 : count - CW'(hit);
      issue    = state != REQ && count_nx != CW'(DEPTH);
      state_nx = state == REQ ? (mem.valid ? GAP : REQ) : issue ? REQ : IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         head_addr  <= RESET_PC;
         drop       <= 1'b0;
         mem.addr   <= '0;
         cpu.valid  <= 1'b0;
         cpu.result <= NOP_INSTR;
      end else begin
         state     <= state_nx;
         head_addr <= head_nx;
         drop      <= !done && (drop || (clear && state == REQ));
         cpu.valid <= hit;
         if (issue) mem.addr <= head_nx + 32'({count_nx, 2'b00});
         if (hit) cpu.result <= fifo_out;
      end
`ifdef PREFETCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         stat_hits      <= '0;
         stat_redirects <= '0;
      end else begin
         stat_hits      <= stat_hits + 32'(cpu.valid);
         stat_redirects <= stat_redirects + 32'(redirect);
      end
`else
   assign stat_hits      = '0;
   assign stat_redirects = '0;
`endif
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: directed scenarios plus randomized traffic, checked against a queue-based model
module tb_instr_prefetch;
   localparam int DEPTH = 4;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] stat_hits, stat_redirects;
   instr_prefetch_if cpu_if();
   instr_prefetch_if mem_if();
   instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .cpu(cpu_if), .mem(mem_if),
      .stat_hits(stat_hits), .stat_redirects(stat_redirects)
   );
   always #5 clk = ~clk;

   int          n_chk = 0, n_err = 0;
   logic [31:0] mq[$];
   logic [31:0] issued[$];
   logic [31:0] m_head, m_addr;
   logic        m_drop, m_cv, m_en;
   int          n_hits, n_redir;
   int          age = 0, lat = 3, lat_cfg = 3;
   bit          rnd = 0, patch_on = 0;
   logic [31:0] patch_addr = 0, patch_val = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (patch_on && a == patch_addr) ? patch_val : a ^ 32'hA5A5A5A5;
   endfunction

   task automatic respond();
      if (mem_if.enable) begin
         age++;
         if (age == 1) lat = rnd ? int'($urandom_range(1, 4)) : lat_cfg;
         mem_if.valid  = age >= lat;
         mem_if.result = memword(mem_if.addr);
      end else begin
         age = 0;
         mem_if.valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         mem_if.result = $urandom;
      end
   endtask

   // one clock: capture driven inputs, let the edge pass, advance the model, compare, respond
   task automatic step();
      logic        ce, fl, mv, hit, redir, done, exp_en, en_p;
      logic [31:0] ca, mr, res;
      ce = cpu_if.enable; ca = cpu_if.addr; fl = flush;
      mv = mem_if.valid;  mr = mem_if.result; en_p = m_en;
      @(negedge clk);
      hit   = !fl && ce && !m_cv && ca == m_head && mq.size() > 0;
      redir = !fl && ce && !m_cv && ca != m_head;
      done  = en_p && mv;
      res   = 32'h0000_0013;
      if (hit) begin
         res = mq.pop_front();
         m_head += 4;
         n_hits++;
      end
      if (fl || redir) begin
         mq.delete();
         if (redir) begin
            m_head = ca;
            n_redir++;
         end
      end else if (done && !m_drop) mq.push_back(mr);
      m_drop = !done && (m_drop || ((fl || redir) && en_p));
      exp_en = en_p ? !mv : mq.size() < DEPTH;
      chk("cpu_valid", cpu_if.valid, hit);
      if (hit) chk("cpu_result", cpu_if.result, res);
      chk("mem_enable", mem_if.enable, exp_en);
      if (exp_en && !en_p) begin
         m_addr = m_head + 32'(4 * mq.size());
         chk("mem_addr", mem_if.addr, m_addr);
      end
      if (exp_en && en_p) chk("mem_addr_hold", mem_if.addr, m_addr);
      if (mem_if.enable && !en_p) issued.push_back(mem_if.addr);
      m_cv = hit;
      m_en = exp_en;
      respond();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cpu_if.enable = 1'b0; flush = 1'b0;
      mem_if.valid = 1'b1; mem_if.result = $urandom;
      #1;
      chk("rst_cpu_valid", cpu_if.valid, 0);
      chk("rst_cpu_result", cpu_if.result, 32'h0000_0013);
      chk("rst_mem_enable", mem_if.enable, 0);
      chk("rst_mem_addr", mem_if.addr, 0);
      chk("rst_stat_hits", stat_hits, 0);
      chk("rst_stat_redirects", stat_redirects, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1; age = 0;
      m_head = 32'h0; m_addr = 32'h0; m_drop = 0; m_cv = 0; m_en = 0;
      mq.delete(); issued.delete(); n_hits = 0; n_redir = 0; patch_on = 0;
   endtask

   task automatic fetch(input logic [31:0] a, output logic [31:0] res, output int l);
      cpu_if.enable = 1'b1; cpu_if.addr = a; l = 0;
      do begin
         step();
         l++;
      end while (!cpu_if.valid && l < 100);
      chk("fetch_done", cpu_if.valid, 1);
      res = cpu_if.result;
      cpu_if.enable = 1'b0;
   endtask

   task automatic idle(input int n);
      cpu_if.enable = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] r, pc;
      int          l, wait_n;
      cpu_if.enable = 0; cpu_if.addr = 0; mem_if.valid = 0; mem_if.result = 0;
      @(negedge clk);
      do_reset();
      fetch(32'h0, r, l);  chk("t1_pc0", r, 32'hA5A5A5A5);
      fetch(32'h4, r, l);  chk("t1_pc4", r, 32'hA5A5A5A1);
      fetch(32'h8, r, l);  chk("t1_pc8", r, 32'hA5A5A5AD);
      idle(20);
      fetch(32'hC, r, l);  chk("t1_hit_latency", l, 1);
      idle(20);
      chk("t2_full_no_req", mem_if.enable, 0);
      fetch(32'h10, r, l); chk("t2_hit_latency", l, 1);
      chk("t2_refill_enable", mem_if.enable, 1);
      chk("t2_refill_addr", mem_if.addr, 32'h20);

      do_reset();
      for (int i = 0; i < 100 && !(mem_if.enable && mem_if.addr == 32'hC); i++) step();
      chk("t3_inflight_0c", mem_if.addr, 32'hC);
      issued.delete();
      fetch(32'h100, r, l); chk("t3_result", r, 32'hA5A5A4A5);
      chk("t3_first_addr", issued.size() > 0 ? issued[0] : '1, 32'h100);
`ifdef PREFETCH_STATS_EN
      chk("t3_stat_redirects", stat_redirects, 1);
`else
      chk("t3_stat_redirects", stat_redirects, 0);
`endif

      do_reset();
      fetch(32'h3C, r, l); chk("t4_pre", r, 32'hA5A5A599);
      idle(30);
      patch_addr = 32'h40; patch_val = 32'hDEADBEEF; patch_on = 1;
      cpu_if.addr = 32'h40; cpu_if.enable = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0;
      chk("t4_flush_no_valid", cpu_if.valid, 0);
      fetch(32'h40, r, l); chk("t4_refetch", r, 32'hDEADBEEF);
      patch_on = 0;

      do_reset();
      fetch(32'hFFFF_FFF8, r, l); chk("t5_fff8", r, 32'h5A5A5A5D);
      idle(20);
      chk("t5_wrap_fffc", issued.size() > 1 ? issued[1] : '1, 32'hFFFF_FFFC);
      chk("t5_wrap_zero", issued.size() > 2 ? issued[2] : '1, 32'h0);
      fetch(32'hFFFF_FFFC, r, l); chk("t5_fffc", r, 32'h5A5A5A59);
      fetch(32'h0, r, l);         chk("t5_zero", r, 32'hA5A5A5A5);

      fetch(32'h200, r, l); chk("t6_pre", r, 32'hA5A5A7A5);
      for (int i = 0; i < 20 && !mem_if.enable; i++) step();
      chk("t6_busy", mem_if.enable, 1);
      do_reset();

      rnd = 1; wait_n = 0; pc = 0;
      cpu_if.addr = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         if (!cpu_if.enable && $urandom_range(0, 3) == 0) begin
            cpu_if.enable = 1'b1;
            wait_n = 0;
         end
         flush = $urandom_range(0, 63) == 0;
         step();
         wait_n++;
         if (cpu_if.valid) begin
            pc = $urandom_range(0, 4) == 0 ? {24'h0, 6'($urandom), 2'b00} : cpu_if.addr + 32'd4;
            cpu_if.addr = pc;
            cpu_if.enable = $urandom_range(0, 2) != 0;
            wait_n = 0;
         end else if (cpu_if.enable && wait_n >= 100) begin
            chk("fetch_timeout", cpu_if.valid, 1);
            cpu_if.enable = 1'b0;
         end
      end
      rnd = 0; flush = 1'b0;
      idle(10);
`ifdef PREFETCH_STATS_EN
      chk("stat_hits", stat_hits, n_hits);
      chk("stat_redirects", stat_redirects, n_redir);
`else
      chk("stat_hits", stat_hits, 0);
      chk("stat_redirects", stat_redirects, 0);
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

Instruction prefetch buffer sitting between the CPU fetch stage and the memory controller's instruction port. Streams sequential instruction words into a small circular buffer ahead of the PC, serving fetches that hit the buffer head in one cycle. Any fetch to a non-head address redirects the stream. Exposes the same enable/valid instruction handshake on both sides, so the CPU's fetch logic is unchanged.

## Interface
- DEPTH, 4: buffer entries; power of two, ≥2
- RESET_PC, 32'h0000_0000: address prefetching starts from after reset
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_addr  in  32  fetch address (PC), stable while cpu_enable high
- cpu_enable  in  1  fetch request, held until cpu_valid
- cpu_result  out  32  instruction word, valid when cpu_valid
- cpu_valid  out  1  one-cycle completion pulse
- flush  in  1  discard buffer, refetch from current head (fence.i, self-modifying code)
- mem_addr  out  32  address to memory controller instruction port
- mem_enable  out  1  memory request, held until mem_valid
- mem_result  in  32  memory read data
- mem_valid  in  1  memory completion; only meaningful while mem_enable high
- stat_hits  out  32  served-fetch counter
- stat_redirects  out  32  redirect counter

## Operation
- State: head_addr (address of oldest entry), count (valid entries), inflight, drop, circular buffer with rd/wr pointers.
- Invariant: the next fetch address is head_addr + 4*count; 32-bit arithmetic, wraps modulo 2^32 silently.
- Issue: when !inflight, not in the post-completion gap cycle, and count < DEPTH: assert mem_enable with mem_addr = head_addr + 4*count; set inflight. Address and enable are held until mem_valid.
- Completion (mem_enable && mem_valid): clear inflight. If !drop, push mem_result and count+1. If drop, discard the data and clear drop.
- Hit (cpu_enable && !cpu_valid && cpu_addr == head_addr && count > 0): register cpu_result = head entry and cpu_valid = 1, pop, head_addr += 4.
- Redirect (cpu_enable && !cpu_valid && cpu_addr != head_addr): count = 0, rd = wr, head_addr = cpu_addr. If a request is in flight, set drop.
- Pending-hit case: cpu_addr == head_addr with count == 0 is not a redirect. The block waits for the fill.
- flush: same as redirect, but head_addr is kept.
- Priority: flush > redirect > hit.
  - flush in the same cycle as a would-be hit suppresses cpu_valid.
  - A completion in the same cycle as a redirect or flush is discarded.
  - A push and a pop in the same cycle leave count unchanged.
- cpu_valid is never high two cycles in a row. The cycle with cpu_valid high evaluates neither hit nor redirect.
- No alignment checking; addresses are compared on the full 32 bits.

## Timing
- Reset values (asynchronous):
  - cpu_valid = 0, cpu_result = 32'h0000_0013 (NOP), mem_enable = 0, mem_addr = 0
  - head_addr = RESET_PC, count = 0, inflight = 0, drop = 0, stats = 0
- First mem_enable is asserted in the first cycle after rst_n deasserts.
- Hit latency: cpu_enable sampled at edge N, cpu_valid high in cycle N+1.
- Fill latency: mem_valid in cycle M, entry visible in cycle M+1, cpu_valid in cycle M+2 at the earliest.
- Memory gap: mem_enable is low for exactly one cycle after each completion. The next request is asserted no earlier than M+2.
- Redirect in cycle R with nothing in flight: new mem_enable is asserted in R+1. With a request in flight, the new request is issued after the dropped completion plus the gap cycle.
- Reset mid-transaction: all state clears immediately. Any later stray mem_valid is ignored because mem_enable is low.

## Configuration
- PREFETCH_STATS_EN defined: stat_hits increments on every cpu_valid, and stat_redirects on every redirect (not on flush). Both are wrapping 32-bit counters, reset to 0.
- PREFETCH_STATS_EN undefined: counter logic is not compiled. Both ports are tied to 32'h0, so the port list is unchanged.

## Structure
- defs package: NOP_INSTR = 32'h0000_0013, and PF_RESET_PC as the shared default for RESET_PC.
- Sub-module instr_pf_fifo holds the DEPTH×32 storage and the rd/wr/count pointers, with push/pop/clear inputs.
- instr_prefetch contains only the address tracking, the memory FSM (IDLE, REQ, GAP) and the CPU-side hit/redirect logic.

## Test plan
- Reset with RESET_PC = 0 and a memory model of latency 3 returning addr^32'hA5A5A5A5; fetch PCs 0, 4, 8 back-to-back → cpu_result values 0xA5A5A5A5, 0xA5A5A5A1, 0xA5A5A5AD. Fetches after the buffer fills complete in 1 cycle.
- Buffer full (count = 4, head 0x10): no mem_enable until a pop. Fetch 0x10 → hit, then mem_addr = 0x20.
- Redirect to 0x100 while a request for 0x0C is in flight → the 0x0C data is dropped, the next mem_addr is 0x100, and cpu_result for 0x100 is correct. stat_redirects = 1 when PREFETCH_STATS_EN is defined.
- flush asserted in the same cycle as a hit on 0x40 → no cpu_valid. Memory is changed at 0x40; the refetch returns the new word.
- head_addr = 0xFFFF_FFF8 → prefetch addresses 0xFFFF_FFFC then 0x0000_0000, with no error.
- rst_n asserted low while mem_enable is high → all outputs return to their reset values in the same cycle.
